// File: rtl/fifo_stream_reader.sv
// Drains a first-word-fall-through FIFO into a valid/ready packet stream through a
// two-entry output buffer. Packets longer than MAX_LEN are cut short and their tails discarded.
module fifo_stream_reader #(
  parameter int DSIZE   = 35,
  parameter int MAX_LEN = 1024
) (
  input  logic             rd_clk,
  input  logic             rd_rst,
  input  logic [DSIZE-1:0] fifo_dout,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  output logic [DSIZE-2:0] m_tdata,
  output logic             m_tlast,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic [31:0]      pkt_cnt,
  output logic             trunc_err,
  output logic             busy,
  output logic             dbg_state
);

  // Output handshake: a beat transfers on any rising edge where m_tvalid && m_tready.
  // While m_tvalid is high and m_tready is low, m_tdata/m_tlast are held.
  // m_tvalid only falls after a transfer, or on reset.

  localparam int          PW   = DSIZE - 1;
  localparam logic [15:0] WMAX = 16'(MAX_LEN - 1);

  typedef enum logic {PASS = 1'b0, DROP = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [PW-1:0]   main_data_q, main_data_d;
  logic            main_last_q, main_last_d;
  logic [PW-1:0]   skid_data_q, skid_data_d;
  logic            skid_last_q, skid_last_d;
  logic [15:0]     wcnt_q, wcnt_d;
  logic [31:0]     pkt_cnt_q, pkt_cnt_d;
  logic            trunc_q, trunc_d;

  logic            rd_en;
  logic            push;
  logic            deq;
  logic            trunc;
  logic            in_last;
  logic            buf_last;
  logic [PW-1:0]   in_data;

  assign in_last  = fifo_dout[DSIZE-1];
  assign in_data  = fifo_dout[PW-1:0];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    main_data_d = main_data_q;
    main_last_d = main_last_q;
    skid_data_d = skid_data_q;
    skid_last_d = skid_last_q;
    wcnt_d      = wcnt_q;
    pkt_cnt_d   = pkt_cnt_q;

    // Pop decision depends only on fifo_empty and registers, never on m_tready.
    rd_en    = !fifo_empty && !rd_rst && ((state_q == DROP) || (cnt_q != 2'd2));
    push     = rd_en && (state_q == PASS);
    deq      = (cnt_q != 2'd0) && m_tready;
    trunc    = push && !in_last && (wcnt_q == WMAX);
    buf_last = in_last || trunc;
    trunc_d  = trunc;

    if (deq && (cnt_q == 2'd2)) begin
      main_data_d = skid_data_q;
      main_last_d = skid_last_q;
    end

    if (push) begin
      if ((cnt_q == 2'd0) || ((cnt_q == 2'd1) && deq)) begin
        main_data_d = in_data;
        main_last_d = buf_last;
      end else begin
        skid_data_d = in_data;
        skid_last_d = buf_last;
      end
      wcnt_d = buf_last ? 16'd0 : wcnt_q + 16'd1;
    end

    case ({push, deq})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase

    if (deq && main_last_q) pkt_cnt_d = pkt_cnt_q + 32'd1;

    // Discard mode ends with the popped word that carries the original last flag.
    case (state_q)
      PASS:    if (trunc) state_d = DROP;
      DROP:    if (rd_en && in_last) state_d = PASS;
      default: state_d = PASS;
    endcase
  end

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      state_q     <= PASS;
      cnt_q       <= 2'd0;
      main_data_q <= '0;
      main_last_q <= 1'b0;
      skid_data_q <= '0;
      skid_last_q <= 1'b0;
      wcnt_q      <= 16'd0;
      pkt_cnt_q   <= 32'd0;
      trunc_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      main_data_q <= main_data_d;
      main_last_q <= main_last_d;
      skid_data_q <= skid_data_d;
      skid_last_q <= skid_last_d;
      wcnt_q      <= wcnt_d;
      pkt_cnt_q   <= pkt_cnt_d;
      trunc_q     <= trunc_d;
    end
  end

  assign fifo_rd_en = rd_en;
  assign m_tvalid   = (cnt_q != 2'd0);
  assign m_tdata    = main_data_q;
  assign m_tlast    = main_last_q;
  assign pkt_cnt    = pkt_cnt_q;
  assign trunc_err  = trunc_q;
  assign busy       = (wcnt_q != 16'd0) || (state_q == DROP);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: FWFT FIFO model on the input, packet-level reference
// (keep the first MAX_LEN words, force last, drop the rest) feeding a scoreboard queue.
module tb_fifo_stream_reader;
  localparam int DSIZE   = 35;
  localparam int PW      = DSIZE - 1;
  localparam int MAX_LEN = 4;

  // clock / reset
  logic             rd_clk = 1'b0;
  logic             rd_rst = 1'b1;
  always #5 rd_clk = ~rd_clk;

  logic [DSIZE-1:0] fifo_dout;
  logic             fifo_empty;
  logic             fifo_rd_en;
  logic [PW-1:0]    m_tdata;
  logic             m_tlast;
  logic             m_tvalid;
  logic             m_tready = 1'b1;
  logic [31:0]      pkt_cnt;
  logic             trunc_err;
  logic             busy;
  logic             dbg_state;

  fifo_stream_reader #(.DSIZE(DSIZE), .MAX_LEN(MAX_LEN)) dut (
    .rd_clk     (rd_clk),
    .rd_rst     (rd_rst),
    .fifo_dout  (fifo_dout),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .m_tdata    (m_tdata),
    .m_tlast    (m_tlast),
    .m_tvalid   (m_tvalid),
    .m_tready   (m_tready),
    .pkt_cnt    (pkt_cnt),
    .trunc_err  (trunc_err),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  int               n_tests = 0;
  int               n_fail  = 0;
  logic [DSIZE-1:0] fifo_q[$];
  logic [DSIZE-1:0] exp_q[$];
  int               exp_pkts = 0;
  int               exp_trunc = 0;
  int               obs_trunc = 0;
  int               pop_cnt = 0;
  int               words_pushed = 0;
  logic             hide = 1'b0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: a packet of len words yields min(len, MAX_LEN) beats, last on the final kept beat.
  task automatic push_pkt(input int len);
    int keep;
    logic [PW-1:0] d;
    keep = (len < MAX_LEN) ? len : MAX_LEN;
    for (int i = 0; i < len; i++) begin
      d = PW'({$urandom(), $urandom()});
      fifo_q.push_back({(i == len - 1) ? 1'b1 : 1'b0, d});
      if (i < keep) exp_q.push_back({(i == keep - 1) ? 1'b1 : 1'b0, d});
    end
    exp_pkts++;
    if (len > MAX_LEN) exp_trunc++;
    words_pushed += len;
  endtask

  task automatic wait_idle(input int bound);
    for (int i = 0; i < bound; i++) begin
      @(negedge rd_clk);
      if (exp_q.size() == 0 && fifo_q.size() == 0 && !m_tvalid) return;
    end
    n_tests++;
    n_fail++;
    $display("FAIL idle_timeout: exp_q=%0d fifo_q=%0d still pending", exp_q.size(), fifo_q.size());
  endtask

  // FWFT FIFO driver: pop decision sampled mid-cycle, head updated just after the edge.
  initial begin
    logic do_pop;
    fifo_empty = 1'b1;
    fifo_dout  = '0;
    forever begin
      @(negedge rd_clk);
      do_pop = fifo_rd_en;
      if (do_pop) begin
        check("rd_en_while_empty", {63'd0, fifo_empty}, 64'd0);
        pop_cnt++;
      end
      @(posedge rd_clk);
      #1;
      if (do_pop && fifo_q.size() > 0) void'(fifo_q.pop_front());
      fifo_empty = hide || (fifo_q.size() == 0);
      fifo_dout  = (fifo_q.size() > 0) ? fifo_q[0] : '0;
    end
  end

  // Scoreboard monitor
  initial begin
    logic             stall_prev = 1'b0;
    logic [DSIZE-1:0] prev_beat = '0;
    logic [DSIZE-1:0] e;
    forever begin
      @(negedge rd_clk);
      if (!rd_rst) begin
        if (trunc_err) obs_trunc++;
        if (stall_prev) begin
          check("stall_valid", {63'd0, m_tvalid}, 64'd1);
          check("stall_data", {29'd0, m_tlast, m_tdata}, {29'd0, prev_beat});
        end
        if (m_tvalid && m_tready) begin
          if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_beat: got %0h with nothing expected", {m_tlast, m_tdata});
          end else begin
            e = exp_q.pop_front();
            check("beat", {29'd0, m_tlast, m_tdata}, {29'd0, e});
          end
        end
        stall_prev = m_tvalid && !m_tready;
        prev_beat  = {m_tlast, m_tdata};
      end
    end
  end

  initial begin
    logic [DSIZE-1:0] a[$];
    int base, t0, cycles;
    logic found, saw_drop;

    // Reset held 3 cycles with a packet waiting in the FIFO
    push_pkt(3);
    @(posedge rd_clk);
    @(negedge rd_clk);
    check("rst_rd_en", {63'd0, fifo_rd_en}, 64'd0);
    check("rst_tvalid", {63'd0, m_tvalid}, 64'd0);
    check("rst_tdata", {30'd0, m_tdata}, 64'd0);
    check("rst_tlast", {63'd0, m_tlast}, 64'd0);
    check("rst_trunc", {63'd0, trunc_err}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_pkt_cnt", {32'd0, pkt_cnt}, 64'd0);
    check("rst_state", {63'd0, dbg_state}, 64'd0);
    repeat (2) begin
      @(negedge rd_clk);
      check("rst_rd_en", {63'd0, fifo_rd_en}, 64'd0);
    end
    @(posedge rd_clk);
    #2 rd_rst = 1'b0;
    wait_idle(100);
    check("pkt_cnt_after_reset_pkt", {32'd0, pkt_cnt}, 64'(exp_pkts));

    // Pass-through latency and back-to-back beats
    push_pkt(4);
    a = exp_q;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge rd_clk);
      if (fifo_rd_en) begin
        found = 1'b1;
        break;
      end
    end
    check("pt_first_pop", {63'd0, found}, 64'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge rd_clk);
      check("pt_tvalid", {63'd0, m_tvalid}, 64'd1);
      check("pt_beat", {29'd0, m_tlast, m_tdata}, {29'd0, a[i]});
      check("pt_rd_en", {63'd0, fifo_rd_en}, (i < 3) ? 64'd1 : 64'd0);
      check("pt_busy", {63'd0, busy}, (i < 3) ? 64'd1 : 64'd0);
    end
    @(negedge rd_clk);
    check("pt_tvalid_end", {63'd0, m_tvalid}, 64'd0);
    check("pt_pkt_cnt", {32'd0, pkt_cnt}, 64'(exp_pkts));

    // Backpressure: only two words fit in the output buffer
    @(posedge rd_clk);
    #2 m_tready = 1'b0;
    push_pkt(4);
    push_pkt(4);
    base = pop_cnt;
    repeat (10) @(negedge rd_clk);
    check("bp_pops", 64'(pop_cnt - base), 64'd2);
    check("bp_rd_en", {63'd0, fifo_rd_en}, 64'd0);
    @(posedge rd_clk);
    #2 m_tready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge rd_clk);
      check("bp_stream_valid", {63'd0, m_tvalid}, 64'd1);
    end
    @(negedge rd_clk);
    check("bp_stream_done", {63'd0, m_tvalid}, 64'd0);
    wait_idle(100);

    // Truncation: 7-word packet cut to 4, tail discarded, then 2-word packet intact
    t0 = obs_trunc;
    saw_drop = 1'b0;
    push_pkt(7);
    push_pkt(2);
    for (int i = 0; i < 30; i++) begin
      @(negedge rd_clk);
      if (dbg_state) saw_drop = 1'b1;
    end
    wait_idle(100);
    check("tr_pulses", 64'(obs_trunc - t0), 64'd1);
    check("tr_saw_drop", {63'd0, saw_drop}, 64'd1);
    check("tr_pkt_cnt", {32'd0, pkt_cnt}, 64'(exp_pkts));
    check("tr_busy", {63'd0, busy}, 64'd0);

    // Boundary: exactly MAX_LEN words ending in last is a normal packet
    t0 = obs_trunc;
    push_pkt(4);
    for (int i = 0; i < 12; i++) begin
      @(negedge rd_clk);
      check("bd_state", {63'd0, dbg_state}, 64'd0);
    end
    wait_idle(100);
    check("bd_pulses", 64'(obs_trunc - t0), 64'd0);
    check("bd_pkt_cnt", {32'd0, pkt_cnt}, 64'(exp_pkts));

    // Random traffic with stalls on both sides
    cycles = 0;
    while (words_pushed < 10000 && cycles < 60000) begin
      @(posedge rd_clk);
      #2;
      m_tready = ($urandom_range(0, 9) < 7);
      hide     = ($urandom_range(0, 9) < 2);
      if (fifo_q.size() < 12) push_pkt(int'($urandom_range(1, 7)));
      cycles++;
    end
    @(posedge rd_clk);
    #2;
    m_tready = 1'b1;
    hide     = 1'b0;
    wait_idle(2000);
    check("final_exp_empty", 64'(exp_q.size()), 64'd0);
    check("final_pkt_cnt", {32'd0, pkt_cnt}, 64'(exp_pkts));
    check("final_trunc", 64'(obs_trunc), 64'(exp_trunc));
    check("final_busy", {63'd0, busy}, 64'd0);
    check("final_state", {63'd0, dbg_state}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
